apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB initiator driving the UART register slave (baud/control/data registers) on the 8-bit-data, 32-bit-address peripheral bus.
- Accepts single read/write commands from a simple valid/ready command port and sequences IDLE -> SETUP -> ACCESS on the bus.
- Returns read data or an error on a one-cycle response port.
- A bounded wait-state counter aborts transfers when the slave never asserts P_ready.

Parameters:
- ADDR_W, 32, width of P_address and cmd_addr
- DATA_W, 8, width of PW_data, PR_data, cmd_wdata, rsp_rdata
- TIMEOUT, 16, maximum ACCESS cycles with P_ready low before abort; 0 disables the timeout

Ports:
- P_clk  in  1  bus clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout abort
- rsp_rdata  out  DATA_W  qualified by rsp_valid; read data
- P_sel  out  1  slave select
- P_enable  out  1  access phase strobe
- P_write  out  1  transfer direction
- P_address  out  ADDR_W  bus address
- PW_data  out  DATA_W  bus write data
- PR_data  in  DATA_W  bus read data
- P_ready  in  1  slave completion / wait-state control

Behaviour:
- Reset (asynchronous, active-high): state IDLE, wait counter 0.
  - All outputs 0: cmd_ready, rsp_valid, rsp_err, rsp_rdata, P_sel, P_enable, P_write, P_address, PW_data.
  - cmd_ready rises in the first cycle after rst deasserts.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE: cmd_ready=1, P_sel=0, P_enable=0.
  - On cmd_valid&&cmd_ready, latch write/addr/wdata into P_write/P_address/PW_data.
  - Go to SETUP.
- SETUP (exactly one cycle): P_sel=1, P_enable=0, cmd_ready=0. Go to ACCESS.
- ACCESS: P_sel=1, P_enable=1; P_address/P_write/PW_data held stable.
  - P_ready sampled at each rising edge.
  - P_ready=1: go to IDLE; next cycle rsp_valid=1, rsp_err=0.
    - rsp_rdata=PR_data sampled on that edge for reads; 0 for writes.
  - P_ready=0: wait counter increments.
  - Counter reaches TIMEOUT (TIMEOUT>0): go to IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Latency with zero wait states:
  - Command accepted at edge 0.
  - SETUP in cycle 1, ACCESS in cycle 2.
  - rsp_valid and cmd_ready high in cycle 3.
  - Each wait state adds one cycle.
- Throughput: the next command may be accepted in the same cycle rsp_valid is high, giving 3 cycles per transfer minimum.
- After completion or abort:
  - P_sel and P_enable return to 0.
  - P_address, P_write and PW_data retain their last values until the next accept.
- The wait counter clears on every accept and is sized to hold TIMEOUT.
- cmd_valid while cmd_ready=0 is ignored. The requester must hold the command until accepted.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_err/rsp_rdata hold until the next rsp_valid.
- rst asserted mid-SETUP/ACCESS: bus drops immediately and no response is issued for the killed transfer.

Decomposition:
- Shared package uart_apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}.
  - UART register address constants: ADDR_BAUD=32'h0, ADDR_CTRL=32'h4, ADDR_TXDATA=32'h8, ADDR_RXDATA=32'hC.
  - Default DATA_W/ADDR_W values.
- Single module, no sub-module. The wait counter is inline.

Test Plan:
- Write with P_ready tied 1: cmd addr=0x0, wdata=0x12, write=1 accepted at edge 0 -> cycle 1 P_sel=1/P_enable=0; cycle 2 P_enable=1, P_address=0x0, PW_data=0x12; cycle 3 rsp_valid=1, rsp_err=0, P_sel=0.
- Read with 2 wait states: addr=0x0, P_ready low for 2 ACCESS cycles, PR_data=0x12 when P_ready=1 -> bus signals stable throughout; rsp_valid in cycle 5 with rsp_rdata=0x12, rsp_err=0.
- Timeout: TIMEOUT=4, P_ready held 0 -> abort after 4 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; P_sel=0 in the response cycle.
- Back-to-back: second command held valid from cycle 1 -> ignored during SETUP/ACCESS; accepted in cycle 3 (rsp_valid cycle); second SETUP in cycle 4.
- Reset mid-ACCESS: assert rst asynchronously during ACCESS -> P_sel/P_enable/cmd_ready go 0 before the next edge; no rsp_valid; after release, cmd_ready=1 and a new write completes normally.
- TIMEOUT=0 with P_ready low for 100 cycles, then high -> no abort; completes with rsp_err=0.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB initiator that drives the UART register slave.
package uart_apb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 8;

  // UART register map as seen on the peripheral bus
  localparam logic [31:0] ADDR_BAUD   = 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0004;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_0008;
  localparam logic [31:0] ADDR_RXDATA = 32'h0000_000C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Bits needed to hold the value 'limit' (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB initiator: one command at a time, IDLE -> SETUP -> ACCESS on the bus,
// registered response pulse, optional wait-state timeout.
module apb_master
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              P_sel,
  output logic              P_enable,
  output logic              P_write,
  output logic [ADDR_W-1:0] P_address,
  output logic [DATA_W-1:0] PW_data,
  input  logic [DATA_W-1:0] PR_data,
  input  logic              P_ready
);

  localparam int unsigned CNT_W  = cnt_width(TIMEOUT);
  localparam bit          TO_EN  = (TIMEOUT != 0);
  // Counter value on the last permitted wait cycle; the next low P_ready aborts
  localparam int unsigned LAST_I = TO_EN ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  apb_state_e       state, state_next;
  logic [CNT_W-1:0] wait_cnt, cnt_next;
  logic             accept, done, abort;

  // Next-state decode, wait-counter update and transfer-end events
  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    accept     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (P_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (TO_EN) begin
          cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and control outputs, all registered from the next state
  always_ff @(posedge P_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      P_sel     <= 1'b0;
      P_enable  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= cnt_next;
      cmd_ready <= (state_next == IDLE);
      P_sel     <= (state_next != IDLE);
      P_enable  <= (state_next == ACCESS);
      rsp_valid <= done | abort;
    end
  end

  // Bus data latched on accept; response fields updated only when a transfer ends
  always_ff @(posedge P_clk or posedge rst) begin
    if (rst) begin
      P_write   <= 1'b0;
      P_address <= '0;
      PW_data   <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        P_write   <= cmd_write;
        P_address <= cmd_addr;
        PW_data   <= cmd_wdata;
      end
      if (done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= P_write ? '0 : PR_data;
      end else if (abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: cycle table of directed sequences,
// randomized transactions against a transaction-level latency/response model,
// asynchronous reset mid-transfer, and a TIMEOUT=0 instance.
module tb_apb_master;
  import uart_apb_pkg::*;

  localparam int TO_A = 4;

  logic        P_clk = 1'b0;
  logic        rst   = 1'b1;

  // Instance A (TIMEOUT=4)
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, P_ready = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [7:0]  cmd_wdata = '0, PR_data = '0;
  logic        cmd_ready, rsp_valid, rsp_err, P_sel, P_enable, P_write;
  logic [7:0]  rsp_rdata, PW_data;
  logic [31:0] P_address;

  // Instance B (TIMEOUT=0)
  logic        cmd_valid_b = 1'b0, cmd_write_b = 1'b0, P_ready_b = 1'b0;
  logic [31:0] cmd_addr_b  = '0;
  logic [7:0]  cmd_wdata_b = '0, PR_data_b = '0;
  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, P_sel_b, P_enable_b, P_write_b;
  logic [7:0]  rsp_rdata_b, PW_data_b;
  logic [31:0] P_address_b;

  int n_vec = 0;
  int n_err = 0;

  apb_master #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(TO_A)) dut_a (
    .P_clk(P_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .P_sel(P_sel), .P_enable(P_enable), .P_write(P_write),
    .P_address(P_address), .PW_data(PW_data), .PR_data(PR_data), .P_ready(P_ready)
  );

  apb_master #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(0)) dut_b (
    .P_clk(P_clk), .rst(rst),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write_b),
    .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
    .P_sel(P_sel_b), .P_enable(P_enable_b), .P_write(P_write_b),
    .P_address(P_address_b), .PW_data(PW_data_b), .PR_data(PR_data_b), .P_ready(P_ready_b)
  );

  always #5 P_clk = ~P_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; land 1ns after the rising edge
  task automatic step();
    @(posedge P_clk);
    #1;
  endtask

  typedef struct packed {
    logic        v, w;
    logic [31:0] a;
    logic [7:0]  d;
    logic        rdy;
    logic [7:0]  prd;
    logic        e_ready, e_sel, e_en, e_rv, e_err;
    logic [7:0]  e_rdata;
    logic [31:0] e_addr;
    logic        e_write;
    logic [7:0]  e_wdata;
  } vec_t;

  function automatic vec_t mk(input int v, input int w, input int a, input int d,
                              input int rdy, input int prd,
                              input int e_ready, input int e_sel, input int e_en,
                              input int e_rv, input int e_err, input int e_rdata,
                              input int e_addr, input int e_write, input int e_wdata);
    vec_t r;
    r.v = v[0]; r.w = w[0]; r.a = 32'(a); r.d = 8'(d);
    r.rdy = rdy[0]; r.prd = 8'(prd);
    r.e_ready = e_ready[0]; r.e_sel = e_sel[0]; r.e_en = e_en[0];
    r.e_rv = e_rv[0]; r.e_err = e_err[0]; r.e_rdata = 8'(e_rdata);
    r.e_addr = 32'(e_addr); r.e_write = e_write[0]; r.e_wdata = 8'(e_wdata);
    return r;
  endfunction

  // One transaction on instance A with w wait states; expectations come from
  // the latency/response rules, not from watching the DUT's state.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [7:0] d,
                         input int w, input logic [7:0] prd);
    bit ab;
    int lat, cyc, acc, bad;
    bit got;
    ab  = (TO_A != 0) && (w >= TO_A);
    lat = ab ? 2 + TO_A : 3 + w;
    for (int i = 0; i < 8 && !cmd_ready; i++) step();
    chk("txn_ready", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    P_ready = 1'($urandom_range(0, 1)); PR_data = 8'($urandom);
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = 8'($urandom);
    cyc = 1; acc = 0; got = 1'b0; bad = 0;
    while (!got && cyc <= 40) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (P_sel && (P_address !== a || P_write !== wr || PW_data !== d)) bad++;
        if (P_enable) begin
          P_ready = (acc == w);
          PR_data = (acc == w) ? prd : 8'($urandom);
          acc++;
        end else begin
          P_ready = 1'($urandom_range(0, 1));
          PR_data = 8'($urandom);
        end
        step();
        cyc++;
      end
    end
    chk("txn_rsp_seen", 32'(got), 32'(1));
    chk("txn_latency", 32'(cyc), 32'(lat));
    chk("txn_err", 32'(rsp_err), 32'(ab));
    chk("txn_rdata", 32'(rsp_rdata), (ab || wr) ? 32'(0) : 32'(prd));
    chk("txn_psel_rsp", 32'(P_sel), 32'(0));
    chk("txn_bus_stable", 32'(bad), 32'(0));
    chk("txn_addr_held", P_address, a);
    P_ready = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 2) != 0) begin
      step();
      chk("txn_pulse", 32'(rsp_valid), 32'(0));
      chk("txn_err_hold", 32'(rsp_err), 32'(ab));
    end
  endtask

  vec_t tbl[22];
  bit   any;

  initial begin
    tbl[0]  = mk(1,1,'h0,'h12,1,'h00, 0,1,0,0,0,'h00,'h0,1,'h12);
    tbl[1]  = mk(0,0,'h0,'h00,1,'h00, 0,1,1,0,0,'h00,'h0,1,'h12);
    tbl[2]  = mk(0,0,'h0,'h00,1,'h00, 1,0,0,1,0,'h00,'h0,1,'h12);
    tbl[3]  = mk(1,0,'h0,'h55,0,'h12, 0,1,0,0,0,'h00,'h0,0,'h55);
    tbl[4]  = mk(0,0,'h0,'h00,0,'h12, 0,1,1,0,0,'h00,'h0,0,'h55);
    tbl[5]  = mk(0,0,'h0,'h00,0,'h12, 0,1,1,0,0,'h00,'h0,0,'h55);
    tbl[6]  = mk(0,0,'h0,'h00,0,'h12, 0,1,1,0,0,'h00,'h0,0,'h55);
    tbl[7]  = mk(0,0,'h0,'h00,1,'h12, 1,0,0,1,0,'h12,'h0,0,'h55);
    tbl[8]  = mk(0,0,'h0,'h00,0,'h00, 1,0,0,0,0,'h12,'h0,0,'h55);
    tbl[9]  = mk(1,0,'h8,'h33,0,'hAA, 0,1,0,0,0,'h12,'h8,0,'h33);
    tbl[10] = mk(0,0,'h0,'h00,0,'hAA, 0,1,1,0,0,'h12,'h8,0,'h33);
    tbl[11] = mk(0,0,'h0,'h00,0,'hAA, 0,1,1,0,0,'h12,'h8,0,'h33);
    tbl[12] = mk(0,0,'h0,'h00,0,'hAA, 0,1,1,0,0,'h12,'h8,0,'h33);
    tbl[13] = mk(0,0,'h0,'h00,0,'hAA, 0,1,1,0,0,'h12,'h8,0,'h33);
    tbl[14] = mk(0,0,'h0,'h00,0,'hAA, 1,0,0,1,1,'h00,'h8,0,'h33);
    tbl[15] = mk(1,1,'h4,'h81,1,'h00, 0,1,0,0,1,'h00,'h4,1,'h81);
    tbl[16] = mk(1,0,'hC,'h7E,1,'h00, 0,1,1,0,1,'h00,'h4,1,'h81);
    tbl[17] = mk(1,0,'hC,'h7E,1,'h00, 1,0,0,1,0,'h00,'h4,1,'h81);
    tbl[18] = mk(1,0,'hC,'h7E,1,'h00, 0,1,0,0,0,'h00,'hC,0,'h7E);
    tbl[19] = mk(0,0,'h0,'h00,0,'h00, 0,1,1,0,0,'h00,'hC,0,'h7E);
    tbl[20] = mk(0,0,'h0,'h00,1,'h5A, 1,0,0,1,0,'h5A,'hC,0,'h7E);
    tbl[21] = mk(0,0,'h0,'h00,0,'h00, 1,0,0,0,0,'h5A,'hC,0,'h7E);

    // Reset state
    repeat (3) @(posedge P_clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    chk("rst_psel", 32'(P_sel), 32'(0));
    chk("rst_penable", 32'(P_enable), 32'(0));
    chk("rst_pwrite", 32'(P_write), 32'(0));
    chk("rst_paddr", P_address, 32'(0));
    chk("rst_pwdata", 32'(PW_data), 32'(0));
    rst = 1'b0;
    chk("rst_release_ready", 32'(cmd_ready), 32'(0));
    step();
    chk("first_cycle_ready", 32'(cmd_ready), 32'(1));

    // Directed cycle table: write, read with waits, timeout, back-to-back
    for (int i = 0; i < 22; i++) begin
      cmd_valid = tbl[i].v; cmd_write = tbl[i].w; cmd_addr = tbl[i].a;
      cmd_wdata = tbl[i].d; P_ready = tbl[i].rdy; PR_data = tbl[i].prd;
      step();
      chk($sformatf("row%0d_cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d_psel", i), 32'(P_sel), 32'(tbl[i].e_sel));
      chk($sformatf("row%0d_penable", i), 32'(P_enable), 32'(tbl[i].e_en));
      chk($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("row%0d_rsp_err", i), 32'(rsp_err), 32'(tbl[i].e_err));
      chk($sformatf("row%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(tbl[i].e_rdata));
      chk($sformatf("row%0d_paddr", i), P_address, tbl[i].e_addr);
      chk($sformatf("row%0d_pwrite", i), 32'(P_write), 32'(tbl[i].e_write));
      chk($sformatf("row%0d_pwdata", i), 32'(PW_data), 32'(tbl[i].e_wdata));
    end
    cmd_valid = 1'b0;

    // Randomized transactions
    for (int t = 0; t < 150; t++) begin
      logic [31:0] ra;
      case ($urandom_range(0, 4))
        0: ra = ADDR_BAUD;
        1: ra = ADDR_CTRL;
        2: ra = ADDR_TXDATA;
        3: ra = ADDR_RXDATA;
        default: ra = $urandom;
      endcase
      run_txn(1'($urandom), ra, 8'($urandom), int'($urandom_range(0, 6)), 8'($urandom));
    end

    // Asynchronous reset during ACCESS
    for (int i = 0; i < 8 && !cmd_ready; i++) step();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_TXDATA; cmd_wdata = 8'h99; P_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_access_penable", 32'(P_enable), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_psel", 32'(P_sel), 32'(0));
    chk("async_rst_penable", 32'(P_enable), 32'(0));
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("async_rst_paddr", P_address, 32'(0));
    @(posedge P_clk);
    #1;
    rst = 1'b0;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    step();
    chk("post_rst_ready", 32'(cmd_ready), 32'(1));
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'(0));
    run_txn(1'b1, ADDR_BAUD, 8'h3C, 0, 8'h00);

    // TIMEOUT=0 instance: long stall never aborts
    for (int i = 0; i < 8 && !cmd_ready_b; i++) step();
    chk("b_ready", 32'(cmd_ready_b), 32'(1));
    cmd_valid_b = 1'b1; cmd_write_b = 1'b0; cmd_addr_b = ADDR_CTRL; P_ready_b = 1'b0; PR_data_b = 8'hC3;
    step();
    cmd_valid_b = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rsp_valid_b) any = 1'b1;
    end
    chk("b_no_abort", 32'(any), 32'(0));
    chk("b_still_access", 32'(P_enable_b), 32'(1));
    P_ready_b = 1'b1;
    step();
    P_ready_b = 1'b0;
    chk("b_rsp_valid", 32'(rsp_valid_b), 32'(1));
    chk("b_rsp_err", 32'(rsp_err_b), 32'(0));
    chk("b_rsp_rdata", 32'(rsp_rdata_b), 32'(8'hC3));
    chk("b_psel_rsp", 32'(P_sel_b), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
